// File: rtl/char_stream_sequencer.sv
// Buffers ASCII bytes and places one glyph per video frame for the VGA character-ROM controller.
// Define CHAR_SEQ_CTRL_CODES_EN to interpret LF/CR/BS and discard other control bytes.
module char_stream_sequencer #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned COLS       = 40,
  parameter int unsigned ROWS       = 30,
  parameter int unsigned CHAR_W     = 16,
  parameter int unsigned CHAR_H     = 16,
  parameter int unsigned X_ORIGIN   = 144,
  parameter int unsigned Y_ORIGIN   = 35
) (
  input  logic                          pixel_clk,
  input  logic                          rst,
  input  logic                          char_valid,
  input  logic [6:0]                    char_data,
  output logic                          char_ready,
  input  logic                          VGA_VS,
  output logic [6:0]                    Character,
  output logic [31:0]                   Char_XLoc,
  output logic [31:0]                   Char_YLoc,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [6:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;
  logic             vs_q;
  logic             frame_evt;
  logic             push;
  logic             pop;
  logic [6:0]       head;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col_nxt;
  logic [ROW_W-1:0] row_nxt;
  logic [ROW_W-1:0] row_inc;
  logic             col_last;
  logic             is_print;
  logic [6:0]       char_nxt;
  logic [31:0]      x_nxt;
  logic [31:0]      y_nxt;

  function automatic logic [31:0] x_of(input logic [COL_W-1:0] c);
    return X_ORIGIN + 32'(c) * CHAR_W;
  endfunction

  function automatic logic [31:0] y_of(input logic [ROW_W-1:0] r);
    return Y_ORIGIN + 32'(r) * CHAR_H;
  endfunction

  assign char_ready = (count != CNT_W'(FIFO_DEPTH));
  assign push       = char_valid && char_ready;
  assign frame_evt  = VGA_VS && !vs_q;
  // Pop looks only at the registered count, so a byte landing this cycle waits a frame.
  assign pop        = frame_evt && (count != '0);
  assign head       = mem[rd_ptr];
  assign fifo_count = count;

  always_ff @(posedge pixel_clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= char_data;
    end
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      vs_q   <= 1'b1;
    end else begin
      vs_q <= VGA_VS;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign col_last = (col == COL_W'(COLS - 1));
  assign row_inc  = (row == ROW_W'(ROWS - 1)) ? '0 : row + 1'b1;

  always_comb begin
`ifdef CHAR_SEQ_CTRL_CODES_EN
    is_print = (head >= 7'h20) && (head != 7'h7F);
`else
    is_print = 1'b1;
`endif
  end

  always_comb begin
    col_nxt  = col;
    row_nxt  = row;
    char_nxt = Character;
    x_nxt    = Char_XLoc;
    y_nxt    = Char_YLoc;
    if (pop && is_print) begin
      char_nxt = head;
      x_nxt    = x_of(col);
      y_nxt    = y_of(row);
      if (col_last) begin
        col_nxt = '0;
        row_nxt = row_inc;
      end else begin
        col_nxt = col + 1'b1;
      end
    end
`ifdef CHAR_SEQ_CTRL_CODES_EN
    else if (pop) begin
      if (head == 7'h0A) begin
        col_nxt = '0;
        row_nxt = row_inc;
      end else if (head == 7'h0D) begin
        col_nxt = '0;
      end else if (head == 7'h08) begin
        // Backspace blanks the cell it steps back onto; at column 0 nothing moves.
        if (col != '0) begin
          col_nxt  = col - 1'b1;
          char_nxt = 7'h20;
          x_nxt    = x_of(col - 1'b1);
          y_nxt    = y_of(row);
        end
      end
    end
`endif
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      Character <= 7'h20;
      Char_XLoc <= X_ORIGIN;
      Char_YLoc <= Y_ORIGIN;
    end else begin
      col       <= col_nxt;
      row       <= row_nxt;
      Character <= char_nxt;
      Char_XLoc <= x_nxt;
      Char_YLoc <= y_nxt;
    end
  end

endmodule

// File: tb/tb_char_stream_sequencer.sv
// Self-checking bench for char_stream_sequencer: directed table, corner sequences, random vs queue model.
module tb_char_stream_sequencer;

  localparam int DEPTH = 16;
  localparam int COLS  = 40;
  localparam int ROWS  = 30;

  logic        pixel_clk = 1'b0;
  logic        rst = 1'b1;
  logic        char_valid = 1'b0;
  logic [6:0]  char_data = '0;
  logic        VGA_VS = 1'b1;
  logic        char_ready;
  logic [6:0]  Character;
  logic [31:0] Char_XLoc;
  logic [31:0] Char_YLoc;
  logic [4:0]  fifo_count;

  char_stream_sequencer dut (
    .pixel_clk (pixel_clk),
    .rst       (rst),
    .char_valid(char_valid),
    .char_data (char_data),
    .char_ready(char_ready),
    .VGA_VS    (VGA_VS),
    .Character (Character),
    .Char_XLoc (Char_XLoc),
    .Char_YLoc (Char_YLoc),
    .fifo_count(fifo_count)
  );

  always #5 pixel_clk = ~pixel_clk;

  int total = 0;
  int bad   = 0;

  // reference model: queue of bytes plus text cursor
  int q[$];
  int m_col, m_row, m_char, m_x, m_y;
  bit m_vsq;

  typedef struct {
    bit v; int d; bit vs;
    int e_char; int e_x; int e_y; int e_cnt;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_col = 0; m_row = 0;
    m_char = 32; m_x = 144; m_y = 35;
    m_vsq = 1'b1;
  endtask

  task automatic model_pop(input int b);
    bit printable;
    printable = 1'b1;
`ifdef CHAR_SEQ_CTRL_CODES_EN
    printable = (b >= 32) && (b != 127);
    if (b == 10) begin
      m_col = 0; m_row = (m_row + 1) % ROWS;
    end else if (b == 13) begin
      m_col = 0;
    end else if (b == 8) begin
      if (m_col > 0) begin
        m_col--;
        m_char = 32; m_x = 144 + m_col * 16; m_y = 35 + m_row * 16;
      end
    end
`endif
    if (printable) begin
      m_char = b; m_x = 144 + m_col * 16; m_y = 35 + m_row * 16;
      m_col++;
      if (m_col == COLS) begin
        m_col = 0; m_row = (m_row + 1) % ROWS;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".char"},  32'(Character),  32'(m_char));
    chk({tag, ".x"},     Char_XLoc,       32'(m_x));
    chk({tag, ".y"},     Char_YLoc,       32'(m_y));
    chk({tag, ".count"}, 32'(fifo_count), 32'(q.size()));
    chk({tag, ".ready"}, 32'(char_ready), 32'(q.size() != DEPTH));
  endtask

  // drive one cycle of inputs, advance the model for the coming edge, then sample 1 ns after it
  task automatic cycle(input bit v, input int d, input bit vs);
    bit evt, do_pop, do_push;
    char_valid = v; char_data = 7'(d); VGA_VS = vs;
    evt     = vs && !m_vsq;
    do_pop  = evt && (q.size() != 0);
    do_push = v && (q.size() != DEPTH);
    if (do_pop) model_pop(q.pop_front());
    if (do_push) q.push_back(d & 127);
    m_vsq = vs;
    @(posedge pixel_clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; char_valid = 1'b0; VGA_VS = 1'b1;
    model_reset();
    @(posedge pixel_clk); #1;
    rst = 1'b0;
    check_all("reset");
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1, 8'h41, 1, 8'h20, 144, 35, 1};
    tbl[1] = '{0, 0,     0, 8'h20, 144, 35, 1};
    tbl[2] = '{0, 0,     1, 8'h41, 144, 35, 0};
    tbl[3] = '{0, 0,     1, 8'h41, 144, 35, 0};
    tbl[4] = '{1, 8'h5A, 0, 8'h41, 144, 35, 1};
    tbl[5] = '{0, 0,     1, 8'h5A, 160, 35, 0};
    tbl[6] = '{0, 0,     0, 8'h5A, 160, 35, 0};
    tbl[7] = '{1, 8'h4B, 1, 8'h5A, 160, 35, 1};
    tbl[8] = '{0, 0,     0, 8'h5A, 160, 35, 1};
    tbl[9] = '{0, 0,     1, 8'h4B, 176, 35, 0};

    model_reset();
    #12;
    do_reset();

    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].vs);
      chk($sformatf("tbl%0d.char", i),  32'(Character),  32'(tbl[i].e_char));
      chk($sformatf("tbl%0d.x", i),     Char_XLoc,       32'(tbl[i].e_x));
      chk($sformatf("tbl%0d.y", i),     Char_YLoc,       32'(tbl[i].e_y));
      chk($sformatf("tbl%0d.count", i), 32'(fifo_count), 32'(tbl[i].e_cnt));
    end

    // full row of 'B' then wrap to row 1
    do_reset();
    for (int i = 0; i <= 40; i++) begin
      cycle(1, (i < 40) ? 8'h42 : 8'h43, 0);
      cycle(0, 0, 1);
      check_all("row");
      if (i == 39) chk("row.last_x", Char_XLoc, 32'd768);
      if (i == 40) begin
        chk("wrap.char", 32'(Character), 32'h43);
        chk("wrap.x", Char_XLoc, 32'd144);
        chk("wrap.y", Char_YLoc, 32'd51);
      end
    end

    // fill to full, then push and pop in the same cycle
    do_reset();
    for (int i = 0; i < 17; i++) cycle(1, 8'h30 + i, 0);
    chk("full.ready", 32'(char_ready), 32'd0);
    chk("full.count", 32'(fifo_count), 32'd16);
    cycle(1, 8'h61, 1);
    chk("fullpop.count", 32'(fifo_count), 32'd15);
    chk("fullpop.ready", 32'(char_ready), 32'd1);
    chk("fullpop.char", 32'(Character), 32'h30);
    check_all("fullpop");
    cycle(0, 0, 1);
    check_all("fullhold");

`ifdef CHAR_SEQ_CTRL_CODES_EN
    do_reset();
    begin
      int seq[5] = '{8'h58, 8'h59, 8'h08, 8'h0A, 8'h50};
      for (int i = 0; i < 5; i++) begin
        cycle(1, seq[i], 0);
        cycle(0, 0, 1);
        check_all("ctrl");
        if (i == 2) begin
          chk("bs.char", 32'(Character), 32'h20);
          chk("bs.x", Char_XLoc, 32'd160);
        end
        if (i == 4) begin
          chk("lf.x", Char_XLoc, 32'd144);
          chk("lf.y", Char_YLoc, 32'd51);
        end
      end
    end
`else
    do_reset();
    cycle(1, 8'h0A, 0);
    cycle(0, 0, 1);
    chk("raw_lf.char", 32'(Character), 32'h0A);
    chk("raw_lf.x", Char_XLoc, 32'd144);
    check_all("raw_lf");
    cycle(1, 8'h51, 0);
    cycle(0, 0, 1);
    chk("raw_lf.adv_x", Char_XLoc, 32'd160);
    check_all("raw_lf2");
`endif

    // asynchronous reset mid-stream
    do_reset();
    for (int i = 0; i < 7; i++) cycle(1, 8'h61 + i, 0);
    cycle(0, 0, 1);
    cycle(0, 0, 0);
    cycle(0, 0, 1);
    chk("pre_rst.count", 32'(fifo_count), 32'd5);
    chk("pre_rst.x", Char_XLoc, 32'd160);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst.count", 32'(fifo_count), 32'd0);
    chk("async_rst.char", 32'(Character), 32'h20);
    chk("async_rst.x", Char_XLoc, 32'd144);
    chk("async_rst.y", Char_YLoc, 32'd35);
    chk("async_rst.ready", 32'(char_ready), 32'd1);
    model_reset();
    VGA_VS = 1'b1;
    @(posedge pixel_clk); #1;
    rst = 1'b0;
    cycle(0, 0, 0);
    cycle(0, 0, 1);
    chk("post_rst.char", 32'(Character), 32'h20);
    chk("post_rst.x", Char_XLoc, 32'd144);
    check_all("post_rst");

    // random traffic: a filling phase then a draining phase
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      bit v, vs;
      int d;
      v = ($urandom_range(0, 99) < ((i < 2000) ? 60 : 10));
      d = $urandom_range(0, 127);
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 4))
          0: d = 8'h08;
          1: d = 8'h0A;
          2: d = 8'h0D;
          3: d = 8'h7F;
          default: d = 8'h01;
        endcase
      end
      vs = ($urandom_range(0, 3) == 0) ? ~VGA_VS : VGA_VS;
      cycle(v, d, vs);
      check_all($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
